// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_pkg
//  Description : Shared constants and types for the SHAKE128 feeder path.
//                RATE128/LANES128 size the rate block, SHAKE_DS/PAD_END are
//                the domain-separation and final padding bytes, and
//                padder_state_t encodes the padder's block-assembly FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package keccak_pkg;

    localparam int RATE128  = 1344;
    localparam int LANES128 = 21;

    localparam logic [7:0] SHAKE_DS = 8'h1F;
    localparam logic [7:0] PAD_END  = 8'h80;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        HOLD   = 2'd1,
        PADBLK = 2'd2
    } padder_state_t;

endpackage : keccak_pkg
`default_nettype wire

// File: rtl/shake128_padder_if.sv
`default_nettype none
// ============================================================================
//  Module      : shake128_padder_if
//  Description : Beat-input / block-output bundle for shake128_padder.
//                s_* : 64-bit message beats in (valid/ready, nbytes, last)
//                m_* : padded RATE-bit blocks out (valid/ready, last)
//                msg_len : byte count, present only when SHAKE_PADDER_LEN_EN
//                          is defined.
//                Modport slave is the padder's view, master the feeder's.
//  Revision    : 1.0 - initial release
// ============================================================================
interface shake128_padder_if
    import keccak_pkg::*;
#(
    parameter int RATE = RATE128
);
    logic            s_valid;
    logic [63:0]     s_data;
    logic [3:0]      s_nbytes;
    logic            s_last;
    logic            s_ready;
    logic            m_valid;
    logic [RATE-1:0] m_block;
    logic            m_last;
    logic            m_ready;
`ifdef SHAKE_PADDER_LEN_EN
    logic [31:0]     msg_len;

    modport slave  (input  s_valid, s_data, s_nbytes, s_last, m_ready,
                    output s_ready, m_valid, m_block, m_last, msg_len);
    modport master (output s_valid, s_data, s_nbytes, s_last, m_ready,
                    input  s_ready, m_valid, m_block, m_last, msg_len);
`else
    modport slave  (input  s_valid, s_data, s_nbytes, s_last, m_ready,
                    output s_ready, m_valid, m_block, m_last);
    modport master (output s_valid, s_data, s_nbytes, s_last, m_ready,
                    input  s_ready, m_valid, m_block, m_last);
`endif
endinterface : shake128_padder_if
`default_nettype wire

// File: rtl/byte_lane_mask.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_mask
//  Description : Combinational decode of a beat's byte count.
//                nbytes  in  4  : raw byte count from the beat
//                last    in  1  : beat is the message tail
//                be_mask out 64 : byte-enable mask (low bytes first)
//                ds_pos  out 4  : effective byte count 0..8, which is also
//                                 the in-lane position of the 0x1F byte
//                                 (8 = first byte of the following lane)
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_mask (
    input  wire logic [3:0]  nbytes,
    input  wire logic        last,
    output logic      [63:0] be_mask,
    output logic      [3:0]  ds_pos
);
    always_comb begin
        // Short counts only mean something on the tail; anything else,
        // including out-of-range counts, is a full beat.
        ds_pos = (last && (nbytes < 4'd8)) ? nbytes : 4'd8;
        for (int j = 0; j < 8; j++) begin
            be_mask[8*j +: 8] = (4'(j) < ds_pos) ? 8'hFF : 8'h00;
        end
    end
endmodule : byte_lane_mask
`default_nettype wire

// File: rtl/shake128_padder.sv
`default_nettype none
// ============================================================================
//  Module      : shake128_padder
//  Description : Assembles 64-bit little-endian message beats into RATE-bit
//                blocks with SHAKE domain separation and pad10*1 padding,
//                and offers them with a valid/ready handshake.
//                clk   in : rising-edge clock
//                rst_n in : synchronous active-low reset
//                clear in : synchronous abort of any partial message/block
//                bus      : shake128_padder_if.slave (s_* beats, m_* blocks,
//                           msg_len when SHAKE_PADDER_LEN_EN is defined)
//                Optional feature macro: SHAKE_PADDER_LEN_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module shake128_padder
    import keccak_pkg::*;
#(
    parameter int RATE   = RATE128,
    parameter int BEAT_W = 64
)(
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         clear,
    shake128_padder_if.slave  bus
);
    localparam int LANES = RATE / BEAT_W;
    localparam int BYTES = RATE / 8;
    localparam int WPW   = $clog2(LANES);
    localparam int PW    = $clog2(BYTES + 1);
    localparam logic [WPW-1:0] LAST_LANE = WPW'(LANES - 1);
    localparam logic [PW-1:0]  FULL_POS  = PW'(BYTES);

    padder_state_t   state_q, state_d;
    logic [WPW-1:0]  wptr_q, wptr_d;
    logic            pad_pend_q, pad_pend_d;
    logic [RATE-1:0] block_q, block_d;
    logic            m_last_q, m_last_d;

    logic [63:0]     be_mask;
    logic [3:0]      ds_pos;
    logic [PW-1:0]   pos;
    logic            accept;

    byte_lane_mask u_mask (
        .nbytes  (bus.s_nbytes),
        .last    (bus.s_last),
        .be_mask (be_mask),
        .ds_pos  (ds_pos)
    );

    // Byte position just past the message tail within the block.
    assign pos    = PW'({wptr_q, 3'b000}) + PW'(ds_pos);
    assign accept = (state_q == FILL) && bus.s_valid;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        pad_pend_d = pad_pend_q;
        block_d    = block_q;
        m_last_d   = m_last_q;

        unique case (state_q)
            FILL: begin
                if (bus.s_valid) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (wptr_q == WPW'(l)) begin
                            block_d[64*l +: 64] = bus.s_data & be_mask;
                        end
                    end
                    if (!bus.s_last) begin
                        if (wptr_q == LAST_LANE) begin
                            wptr_d   = '0;
                            state_d  = HOLD;
                            m_last_d = 1'b0;
                        end else begin
                            wptr_d = wptr_q + 1'b1;
                        end
                    end else begin
                        wptr_d  = '0;
                        state_d = HOLD;
                        if (pos == FULL_POS) begin
                            // Message filled the block exactly; padding
                            // needs a block of its own afterwards.
                            pad_pend_d = 1'b1;
                            m_last_d   = 1'b0;
                        end else begin
                            // Lanes past wptr are still zero, so a full
                            // tail beat puts 0x1F at byte 0 of the next lane.
                            for (int k = 0; k < BYTES; k++) begin
                                if (pos == PW'(k)) begin
                                    block_d[8*k +: 8] = block_d[8*k +: 8] ^ SHAKE_DS;
                                end
                            end
                            block_d[RATE-1 -: 8] = block_d[RATE-1 -: 8] | PAD_END;
                            m_last_d = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    block_d = '0;
                    if (pad_pend_q) begin
                        block_d[7:0]         = SHAKE_DS;
                        block_d[RATE-1 -: 8] = PAD_END;
                        pad_pend_d = 1'b0;
                        state_d    = PADBLK;
                        m_last_d   = 1'b1;
                    end else begin
                        state_d  = FILL;
                        m_last_d = 1'b0;
                    end
                end
            end
            PADBLK: begin
                if (bus.m_ready) begin
                    block_d  = '0;
                    state_d  = FILL;
                    m_last_d = 1'b0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        if (clear) begin
            state_d    = FILL;
            wptr_d     = '0;
            pad_pend_d = 1'b0;
            block_d    = '0;
            m_last_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FILL;
            wptr_q     <= '0;
            pad_pend_q <= 1'b0;
            block_q    <= '0;
            m_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            pad_pend_q <= pad_pend_d;
            block_q    <= block_d;
            m_last_q   <= m_last_d;
        end
    end

    assign bus.s_ready = (state_q == FILL);
    assign bus.m_valid = (state_q != FILL);
    assign bus.m_block = block_q;
    assign bus.m_last  = m_last_q;

`ifdef SHAKE_PADDER_LEN_EN
    logic [31:0] msg_len_q, msg_len_d;
    logic [32:0] len_sum;

    always_comb begin
        msg_len_d = msg_len_q;
        len_sum   = {1'b0, msg_len_q} + 33'(ds_pos);
        if (accept) begin
            msg_len_d = len_sum[32] ? 32'hFFFF_FFFF : len_sum[31:0];
        end
        // Accepts only happen in FILL, so this never collides with them.
        if (bus.m_ready && (state_q != FILL) && m_last_q) begin
            msg_len_d = '0;
        end
        if (clear) begin
            msg_len_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msg_len_q <= '0;
        end else begin
            msg_len_q <= msg_len_d;
        end
    end

    assign bus.msg_len = msg_len_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule : shake128_padder
`default_nettype wire

// File: tb/tb_shake128_padder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shake128_padder
//  Description : Randomized scoreboard bench for shake128_padder. Messages
//                are byte queues; the reference pads them as a whole
//                (msg || 0x1F || 0* , last byte |= 0x80) and slices the
//                result into blocks. A monitor pops and compares every
//                accepted block. Honors SHAKE_PADDER_LEN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shake128_padder;
    import keccak_pkg::*;

    localparam int BYTES = RATE128 / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    shake128_padder_if #(.RATE(RATE128)) bus ();

    shake128_padder #(.RATE(RATE128), .BEAT_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [RATE128-1:0] blk;
        logic               last;
        logic [31:0]        len;
        bit                 imm;
    } exp_t;

    exp_t sb[$];
    int   n_checks    = 0;
    int   n_errors    = 0;
    bit   stall_en    = 1'b0;
    bit   stall_val   = 1'b0;
    bit   imm_pending = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [RATE128-1:0] act,
                           input logic [RATE128-1:0] exp);
        int k;
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            k = 0;
            while (k < BYTES - 1 && act[8*k +: 8] === exp[8*k +: 8]) k++;
            $display("FAIL %s: byte %0d got %02h expected %02h", name, k,
                     act[8*k +: 8], exp[8*k +: 8]);
        end
    endtask

    // Reference: pad the whole message, then cut into rate-sized blocks.
    task automatic push_expected(input logic [7:0] msg[$]);
        logic [7:0] padded[$];
        int         nblk;
        exp_t       e;
        padded = msg;
        padded.push_back(SHAKE_DS);
        while (padded.size() % BYTES != 0) padded.push_back(8'h00);
        padded[padded.size()-1] = padded[padded.size()-1] | PAD_END;
        nblk = padded.size() / BYTES;
        for (int b = 0; b < nblk; b++) begin
            e.blk = '0;
            for (int k = 0; k < BYTES; k++) e.blk[8*k +: 8] = padded[b*BYTES + k];
            e.last = (b == nblk - 1);
            e.len  = 32'(msg.size());
            e.imm  = e.last && (msg.size() > 0) && (msg.size() % BYTES == 0);
            sb.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic drive_beat(input logic [63:0] d, input logic [3:0] nb, input bit last);
        int t = 0;
        bus.s_valid  = 1'b1;
        bus.s_data   = d;
        bus.s_nbytes = nb;
        bus.s_last   = last;
        forever begin
            @(negedge clk);
            if (bus.s_ready) break;
            t++;
            if (t > 2000) begin
                n_checks++;
                n_errors++;
                $display("FAIL s_ready_timeout: got 0 expected 1");
                break;
            end
        end
        @(posedge clk); #1;
        bus.s_valid  = 1'b0;
        bus.s_last   = 1'b0;
        bus.s_data   = {$urandom, $urandom};
        bus.s_nbytes = 4'($urandom_range(0, 15));
    endtask

    task automatic send_msg(input logic [7:0] msg[$], input bit gaps);
        int          n;
        int          nb;
        int          cnt;
        bit          last;
        logic [63:0] d;
        logic [3:0]  nbf;
        n  = msg.size();
        nb = (n == 0) ? 1 : (n + 7) / 8;
        push_expected(msg);
        for (int b = 0; b < nb; b++) begin
            cnt = n - 8*b;
            if (cnt > 8) cnt = 8;
            d = {$urandom, $urandom};
            for (int j = 0; j < cnt; j++) d[8*j +: 8] = msg[8*b + j];
            last = (b == nb - 1);
            if (cnt < 8)                          nbf = 4'(cnt);
            else if ($urandom_range(0, 3) != 0)   nbf = 4'd8;
            else if (last)                        nbf = 4'($urandom_range(9, 15));
            else                                  nbf = 4'($urandom_range(0, 15));
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            end
            drive_beat(d, nbf, last);
        end
    endtask

    // Returns at a negedge once all expected blocks are consumed.
    task automatic drain();
        int t = 0;
        forever begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.m_valid) break;
            t++;
            if (t > 5000) begin
                n_checks++;
                n_errors++;
                $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
                break;
            end
        end
    endtask

    task automatic wait_mvalid();
        int t = 0;
        forever begin
            @(negedge clk);
            if (bus.m_valid) break;
            t++;
            if (t > 100) begin
                n_checks++;
                n_errors++;
                $display("FAIL m_valid_timeout: got 0 expected 1");
                break;
            end
        end
    endtask

    // Sink readiness: random unless a directed test pins it.
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            bus.m_ready = stall_en ? stall_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (imm_pending) begin
                    imm_pending = 1'b0;
                    chk("pad_blk_latency", 64'(bus.m_valid), 64'd1);
                end
                if (bus.m_valid && bus.m_ready && !clear) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_block: got block expected none");
                    end else begin
                        e = sb.pop_front();
                        chk_blk("block", bus.m_block, e.blk);
                        chk("m_last", 64'(bus.m_last), 64'(e.last));
`ifdef SHAKE_PADDER_LEN_EN
                        if (e.last) chk("msg_len", 64'(bus.msg_len), 64'(e.len));
`endif
                        if (!e.last && sb.size() > 0 && sb[0].imm) imm_pending = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0]         m[$];
        logic [RATE128-1:0] cap_blk;
        logic               cap_last;
        logic [RATE128-1:0] abc_blk;

        abc_blk          = '0;
        abc_blk[31:0]    = 32'h1F63_6261;
        abc_blk[RATE128-1 -: 8] = 8'h80;

        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.s_nbytes = '0;
        bus.s_last   = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_s_ready", 64'(bus.s_ready), 64'd1);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_m_last",  64'(bus.m_last),  64'd0);
        chk_blk("rst_block", bus.m_block, '0);
`ifdef SHAKE_PADDER_LEN_EN
        chk("rst_msg_len", 64'(bus.msg_len), 64'd0);
`endif
        @(posedge clk); #1;

        // Directed lengths: empty, "abc", 167 (0x9F), 168 (extra pad block).
        m.delete();
        send_msg(m, 1'b0);
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0);
        m.delete();
        for (int i = 0; i < 167; i++) m.push_back(8'($urandom));
        send_msg(m, 1'b0);
        m.delete();
        for (int i = 0; i < 168; i++) m.push_back(8'($urandom));
        send_msg(m, 1'b0);

        // Random lengths, including multi-block and exact-multiple cases.
        for (int r = 0; r < 14; r++) begin
            int len;
            case (r % 4)
                0:       len = 336;
                1:       len = $urandom_range(160, 176);
                default: len = $urandom_range(0, 400);
            endcase
            m.delete();
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            send_msg(m, 1'b1);
        end
        drain();
        @(posedge clk); #1;

        // Backpressure: held block must not move, no beats taken.
        stall_en  = 1'b1;
        stall_val = 1'b0;
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0);
        wait_mvalid();
        cap_blk  = bus.m_block;
        cap_last = bus.m_last;
        chk_blk("abc_literal", cap_blk, abc_blk);
        chk("abc_last", 64'(cap_last), 64'd1);
        repeat (10) begin
            @(negedge clk);
            chk_blk("stall_block", bus.m_block, cap_blk);
            chk("stall_last",    64'(bus.m_last),  64'(cap_last));
            chk("stall_s_ready", 64'(bus.s_ready), 64'd0);
            chk("stall_m_valid", 64'(bus.m_valid), 64'd1);
        end
        @(posedge clk); #1;
        stall_val = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_s_ready", 64'(bus.s_ready), 64'd1);
        chk("release_m_valid", 64'(bus.m_valid), 64'd0);
        stall_en = 1'b0;
        drain();
        @(posedge clk); #1;

        // Clear mid-fill after 5 beats, then "abc" must match standalone.
        for (int b = 0; b < 5; b++) drive_beat({$urandom, $urandom}, 4'd8, 1'b0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear_s_ready", 64'(bus.s_ready), 64'd1);
        chk("clear_m_valid", 64'(bus.m_valid), 64'd0);
        @(posedge clk); #1;
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0);
        drain();
        @(posedge clk); #1;

        // Clear while a block is offered and m_ready=1: block is withdrawn.
        stall_en  = 1'b1;
        stall_val = 1'b0;
        for (int b = 0; b < 21; b++) drive_beat({$urandom, $urandom}, 4'd8, 1'b0);
        wait_mvalid();
        @(posedge clk); #1;
        clear     = 1'b1;
        stall_val = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;
        stall_en = 1'b0;
        @(negedge clk);
        chk("withdraw_m_valid", 64'(bus.m_valid), 64'd0);
        chk("withdraw_s_ready", 64'(bus.s_ready), 64'd1);
        chk_blk("withdraw_block", bus.m_block, '0);
        @(posedge clk); #1;
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b1);
        drain();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_shake128_padder
`default_nettype wire

// File: doc/shake128_padder.md
# shake128_padder

Upstream feeder for `shake128_pipelined`. It accepts a message as a stream of 64-bit little-endian beats and assembles 1344-bit rate blocks. It applies the SHAKE domain-separation and pad10*1 padding (0x1F … 0x80). It presents each block with the `in_valid`/`in_block`/`in_last`/`in_ready` handshake that the permutation core expects.

## Interface
Parameters:
- `RATE`, 1344: rate in bits; must be a multiple of 64.
- `BEAT_W`, 64: input beat width in bits; fixed at 64.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `clear`  in  1  synchronous abort; drops any partial block or message.
- `s_valid`  in  1  input beat valid.
- `s_data`  in  64  message bytes; byte j is at `s_data[8j +: 8]`.
- `s_nbytes`  in  4  valid bytes in the beat, 0..8, low bytes first.
  - Values <8 are legal only with `s_last`.
  - 0 is legal only with `s_last` (empty tail).
- `s_last`  in  1  final beat of the message.
- `s_ready`  out  1  beat accepted when `s_valid & s_ready`.
- `m_valid`  out  1  block valid; drives core `in_valid`.
- `m_block`  out  RATE  padded block; message byte k is at `[8k +: 8]`.
- `m_last`  out  1  final block of the message; drives core `in_last`.
- `m_ready`  in  1  from core `in_ready`.

## Operation
- States:
  - FILL: `s_ready=1`, `m_valid=0`.
  - HOLD: `m_valid=1`, `s_ready=0`.
  - PADBLK: `m_valid=1`, `s_ready=0`; `m_block` is pad-only.
- Word pointer `wptr` (0..RATE/64-1 = 0..20) indexes the 64-bit lanes of the block register.
- Accepting a beat in FILL:
  - Writes its valid bytes to lane `wptr`; bytes at index ≥ `s_nbytes` are written as 0.
  - Without `s_last`: `wptr++`. If `wptr` was 20, go to HOLD with `m_last=0` and `wptr=0`.
  - With `s_last` and the message byte position p = 8·`wptr`+`s_nbytes` < 168:
    - XOR 0x1F into byte p, then OR 0x80 into byte 167. At p=167 the byte becomes 0x9F.
    - Go to HOLD with `m_last=1`.
  - With `s_last` and p = 168 (full last lane, `wptr`=20): go to HOLD with `m_last=0`, and set pending flag `pad_pend`.
- HOLD, on `m_valid & m_ready`:
  - If `pad_pend`: load the pad-only block (byte 0 = 0x1F, byte 167 = 0x80, rest 0), clear `pad_pend`, go to PADBLK with `m_last=1`.
  - Otherwise: zero the block register, go to FILL.
- PADBLK, on handshake: zero the block register, go to FILL.
- `m_block` and `m_last` are stable while `m_valid=1 & m_ready=0`.
- `clear` (priority below reset, above all else):
  - Zeroes the block register, `wptr` and `pad_pend`, and goes to FILL next cycle.
  - A block being offered in that cycle is withdrawn even if `m_ready=1`; upstream must also pulse core `init`.
- Illegal `s_nbytes` (>8, or <8 without `s_last`) is treated as 8. No error output.

## Timing
- Reset values: state FILL, `s_ready=1` (first cycle after reset release), `m_valid=0`, `m_last=0`, `m_block=0`, `wptr=0`, `pad_pend=0`.
- Throughput: one beat per cycle in FILL.
- Latency: `m_valid` rises the cycle after the edge that accepts lane 20 or the last beat.
- `s_ready` rises the cycle after the final block handshake. Bubble between blocks: 1 cycle minimum.
- Pad-only block: offered the cycle after the preceding block's handshake.
- All outputs are registered. No combinational path from `m_ready` to `s_ready`.

## Configuration
- `SHAKE_PADDER_LEN_EN` defined:
  - Adds output `msg_len` (32 bits): count of message bytes accepted since the last reset, `clear`, or final-block handshake.
  - Saturates at 0xFFFFFFFF. Reset value 0.
  - Valid and stable while `m_last=1 & m_valid=1`.
- Undefined: port absent; counter logic not built.

## Structure
- Shared package `keccak_pkg`:
  - `RATE128=1344`, `LANES128=21`.
  - `SHAKE_DS=8'h1F`, `PAD_END=8'h80`.
  - `padder_state_t` enum {FILL, HOLD, PADBLK}.
- One sub-module, `byte_lane_mask`: combinational expansion of `s_nbytes` to a 64-bit byte-enable mask and to the 0x1F insertion position. Everything else stays in `shake128_padder`.

## Test plan
- Empty message: one beat with `s_nbytes=0`, `s_last=1` → one block, byte0=0x1F, byte167=0x80, rest 0, `m_last=1`. Chained core digest = 7f9c2ba4e88f827d616045507605853e.
- "abc": `s_data=64'h636261`, `s_nbytes=3`, `s_last=1` → bytes 61 62 63 1F, byte167=0x80. Digest 5881092dd818bf5cf8a3ddb793fbcba7.
- 167-byte message (20 full beats + 7 bytes) → single block, byte167=0x9F, `m_last=1`.
- 168-byte message (21 full beats, last with `s_last`) → data block with `m_last=0`, then pad-only block (0x1F/0x80) with `m_last=1` the cycle after its handshake.
- Backpressure: hold `m_ready=0` for 10 cycles in HOLD → `m_block`/`m_last` unchanged and `s_ready=0` throughout. Completion follows 1 cycle after `m_ready` rises.
- Clear mid-fill after 5 beats, then send "abc" → output equals the standalone "abc" block. Under `SHAKE_PADDER_LEN_EN`, `msg_len=3`.
